gpr_wb_arb: RTL and testbench

GPR_WB_ARB -- requirements
Module: gpr_wb_arb

---
 rtl/gpr_wb_arb.sv | 193 +++++++++++++++++++
 tb/tb_gpr_wb_arb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arb.sv
// gpr_wb_arb
// Writeback arbiter in front of the general-purpose register file. Each
// writeback source has a one-entry skid buffer. Full buffers compete for a
// single registered GPR write port that can take one write per cycle.
//
// Priority: the LSU normally beats the EXE. A starvation counter lets a
// waiting EXE entry win once it has lost three arbitrations in a row.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   exe_valid/ready/rd/data        execute-stage writeback request
//   lsu_valid/ready/rd/data        load-unit writeback request
//   gpr_we, gpr_en                 GPR write strobe and enable (always equal)
//   gpr_addr_rd, gpr_data_rd       GPR write address and data (registered)
//   busy_mask                      bit r set while a write to rd r is in flight
//   dbg_valid/ready/rd/data        debug writeback request, present only
//                                  when GPR_WB_DBG_PORT_EN is defined
//
// Optional feature: define GPR_WB_DBG_PORT_EN to add a third, lowest-priority
// debug source. It is granted only when both the EXE and LSU buffers are empty.
module gpr_wb_arb #(
  parameter  int REG_WIDTH = 32,
  parameter  int GPRN      = 32,
  localparam int AW        = $clog2(GPRN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exe_valid,
  output logic                 exe_ready,
  input  logic [AW-1:0]        exe_rd,
  input  logic [REG_WIDTH-1:0] exe_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [AW-1:0]        lsu_rd,
  input  logic [REG_WIDTH-1:0] lsu_data,
  output logic                 gpr_we,
  output logic                 gpr_en,
  output logic [AW-1:0]        gpr_addr_rd,
  output logic [REG_WIDTH-1:0] gpr_data_rd,
  output logic [GPRN-1:0]      busy_mask
`ifdef GPR_WB_DBG_PORT_EN
  ,
  input  logic                 dbg_valid,
  output logic                 dbg_ready,
  input  logic [AW-1:0]        dbg_rd,
  input  logic [REG_WIDTH-1:0] dbg_data
`endif
);

  logic                 exe_full;
  logic [AW-1:0]        exe_rd_q;
  logic [REG_WIDTH-1:0] exe_data_q;
  logic                 lsu_full;
  logic [AW-1:0]        lsu_rd_q;
  logic [REG_WIDTH-1:0] lsu_data_q;
  logic [1:0]           exe_wait;

  logic                 gnt_exe;
  logic                 gnt_lsu;
  logic                 any_gnt;
  logic [AW-1:0]        sel_rd;
  logic [REG_WIDTH-1:0] sel_data;

`ifdef GPR_WB_DBG_PORT_EN
  logic                 dbg_full;
  logic [AW-1:0]        dbg_rd_q;
  logic [REG_WIDTH-1:0] dbg_data_q;
  logic                 gnt_dbg;
`endif

  // The grant depends only on buffer state, not on the incoming valids.
  // Because of that, a ready can never combinationally depend on its own valid.
  always_comb begin
    gnt_exe  = 1'b0;
    gnt_lsu  = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
`ifdef GPR_WB_DBG_PORT_EN
    gnt_dbg  = 1'b0;
`endif
    if (exe_full && exe_wait == 2'd3) begin
      // A starved EXE entry overrides the normal LSU priority.
      gnt_exe  = 1'b1;
      sel_rd   = exe_rd_q;
      sel_data = exe_data_q;
    end else if (lsu_full) begin
      gnt_lsu  = 1'b1;
      sel_rd   = lsu_rd_q;
      sel_data = lsu_data_q;
    end else if (exe_full) begin
      gnt_exe  = 1'b1;
      sel_rd   = exe_rd_q;
      sel_data = exe_data_q;
`ifdef GPR_WB_DBG_PORT_EN
    end else if (dbg_full) begin
      gnt_dbg  = 1'b1;
      sel_rd   = dbg_rd_q;
      sel_data = dbg_data_q;
`endif
    end
  end

`ifdef GPR_WB_DBG_PORT_EN
  assign any_gnt   = gnt_exe | gnt_lsu | gnt_dbg;
  assign dbg_ready = rst_n & (~dbg_full | gnt_dbg);
`else
  assign any_gnt   = gnt_exe | gnt_lsu;
`endif

  // A buffer can accept when it is empty, or when it is being drained this
  // cycle. Accepting while draining keeps one write per cycle sustainable.
  // Holding ready low during reset makes the source keep its request.
  assign exe_ready = rst_n & (~exe_full | gnt_exe);
  assign lsu_ready = rst_n & (~lsu_full | gnt_lsu);

  assign gpr_en = gpr_we;

  // Every in-flight destination is marked busy. The output register counts
  // only while its write strobe is up. A write to rd 0 never marks anything.
  always_comb begin
    busy_mask = '0;
    if (exe_full) busy_mask[exe_rd_q] = 1'b1;
    if (lsu_full) busy_mask[lsu_rd_q] = 1'b1;
`ifdef GPR_WB_DBG_PORT_EN
    if (dbg_full) busy_mask[dbg_rd_q] = 1'b1;
`endif
    if (gpr_we)   busy_mask[gpr_addr_rd] = 1'b1;
    busy_mask[0] = 1'b0;
  end

  // Buffer refill takes precedence over drain, so a same-cycle grant plus a
  // new transfer leaves the buffer full with the new entry. A granted rd 0
  // entry uses up its slot, but it leaves the address and data registers
  // holding their previous contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exe_full    <= 1'b0;
      exe_rd_q    <= '0;
      exe_data_q  <= '0;
      lsu_full    <= 1'b0;
      lsu_rd_q    <= '0;
      lsu_data_q  <= '0;
      exe_wait    <= 2'd0;
      gpr_we      <= 1'b0;
      gpr_addr_rd <= '0;
      gpr_data_rd <= '0;
`ifdef GPR_WB_DBG_PORT_EN
      dbg_full    <= 1'b0;
      dbg_rd_q    <= '0;
      dbg_data_q  <= '0;
`endif
    end else begin
      if (exe_valid && exe_ready) begin
        exe_full   <= 1'b1;
        exe_rd_q   <= exe_rd;
        exe_data_q <= exe_data;
      end else if (gnt_exe) begin
        exe_full   <= 1'b0;
      end

      if (lsu_valid && lsu_ready) begin
        lsu_full   <= 1'b1;
        lsu_rd_q   <= lsu_rd;
        lsu_data_q <= lsu_data;
      end else if (gnt_lsu) begin
        lsu_full   <= 1'b0;
      end

`ifdef GPR_WB_DBG_PORT_EN
      if (dbg_valid && dbg_ready) begin
        dbg_full   <= 1'b1;
        dbg_rd_q   <= dbg_rd;
        dbg_data_q <= dbg_data;
      end else if (gnt_dbg) begin
        dbg_full   <= 1'b0;
      end
`endif

      if (gnt_exe) begin
        exe_wait <= 2'd0;
      end else if (exe_full && exe_wait != 2'd3) begin
        exe_wait <= exe_wait + 2'd1;
      end

      gpr_we <= any_gnt && (sel_rd != '0);
      if (any_gnt && (sel_rd != '0)) begin
        gpr_addr_rd <= sel_rd;
        gpr_data_rd <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_arb.sv
// tb_gpr_wb_arb
// Self-checking bench for gpr_wb_arb. Expected GPR writes are queued in
// predicted grant order when stimulus is applied. A monitor pops and compares
// them whenever gpr_we is seen. Directed checks cover reset state, latency,
// readies, busy_mask and the rd 0 case.
module tb_gpr_wb_arb;
  localparam int REG_WIDTH = 32;
  localparam int GPRN      = 32;
  localparam int AW        = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 exe_valid, exe_ready, lsu_valid, lsu_ready;
  logic [AW-1:0]        exe_rd, lsu_rd, gpr_addr_rd;
  logic [REG_WIDTH-1:0] exe_data, lsu_data, gpr_data_rd;
  logic                 gpr_we, gpr_en;
  logic [GPRN-1:0]      busy_mask;
`ifdef GPR_WB_DBG_PORT_EN
  logic                 dbg_valid = 1'b0;
  logic                 dbg_ready;
  logic [AW-1:0]        dbg_rd = '0;
  logic [REG_WIDTH-1:0] dbg_data = '0;
`endif

  typedef struct packed {
    logic [AW-1:0]        rd;
    logic [REG_WIDTH-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad   = 0;
  int  guard;
  int  stalls;

  gpr_wb_arb #(.REG_WIDTH(REG_WIDTH), .GPRN(GPRN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exe_valid   (exe_valid),
    .exe_ready   (exe_ready),
    .exe_rd      (exe_rd),
    .exe_data    (exe_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .gpr_we      (gpr_we),
    .gpr_en      (gpr_en),
    .gpr_addr_rd (gpr_addr_rd),
    .gpr_data_rd (gpr_data_rd),
    .busy_mask   (busy_mask)
`ifdef GPR_WB_DBG_PORT_EN
    ,
    .dbg_valid   (dbg_valid),
    .dbg_ready   (dbg_ready),
    .dbg_rd      (dbg_rd),
    .dbg_data    (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic [AW-1:0] erd,
                               input logic [REG_WIDTH-1:0] edat,
                               input logic lv, input logic [AW-1:0] lrd,
                               input logic [REG_WIDTH-1:0] ldat);
    exe_valid = ev;
    exe_rd    = erd;
    exe_data  = edat;
    lsu_valid = lv;
    lsu_rd    = lrd;
    lsu_data  = ldat;
  endtask

  task automatic cycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expectWrite(input logic [AW-1:0] rd, input logic [REG_WIDTH-1:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Waits a bounded number of cycles for every queued write to appear.
  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      cycle(1);
      g++;
    end
    checkOutput(tag, 64'(exp_q.size()), 64'd0);
    cycle(1);
  endtask

  // Scoreboard monitor: every observed write must match the oldest expectation.
  always @(negedge clk) begin
    if (gpr_we || gpr_en) checkOutput("en_eq_we", 64'(gpr_en), 64'(gpr_we));
    if (gpr_we) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_we", 64'(gpr_addr_rd), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_addr", 64'(gpr_addr_rd), 64'(mon_e.rd));
        checkOutput("sb_data", 64'(gpr_data_rd), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(0, '0, '0, 0, '0, '0);
    rst_n = 1'b0;
    cycle(2);
    checkOutput("rst_we",        64'(gpr_we), 64'd0);
    checkOutput("rst_en",        64'(gpr_en), 64'd0);
    checkOutput("rst_addr",      64'(gpr_addr_rd), 64'd0);
    checkOutput("rst_data",      64'(gpr_data_rd), 64'd0);
    checkOutput("rst_busy",      64'(busy_mask), 64'd0);
    checkOutput("rst_exe_ready", 64'(exe_ready), 64'd0);
    checkOutput("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_exe_ready", 64'(exe_ready), 64'd1);
    checkOutput("post_rst_lsu_ready", 64'(lsu_ready), 64'd1);

    // Single EXE write, two edges from accept to write strobe.
    cycle(1);
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    expectWrite(5'd5, 32'hDEADBEEF);
    checkOutput("t27_ready", 64'(exe_ready), 64'd1);
    cycle(1);
    applyStimulus(0, '0, '0, 0, '0, '0);
    checkOutput("t27_busy_e0", 64'(busy_mask), 64'h20);
    checkOutput("t27_we_e0",   64'(gpr_we), 64'd0);
    cycle(1);
    checkOutput("t27_we_e1",   64'(gpr_we), 64'd1);
    checkOutput("t27_addr_e1", 64'(gpr_addr_rd), 64'd5);
    checkOutput("t27_data_e1", 64'(gpr_data_rd), 64'hDEADBEEF);
    checkOutput("t27_busy_e1", 64'(busy_mask), 64'h20);
    cycle(1);
    checkOutput("t27_we_e2",   64'(gpr_we), 64'd0);
    checkOutput("t27_busy_e2", 64'(busy_mask), 64'd0);
    drain("t27_drain");

    // Simultaneous requests: LSU wins first, EXE follows next cycle.
    applyStimulus(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    expectWrite(5'd4, 32'h22);
    expectWrite(5'd3, 32'h11);
    checkOutput("t28_exe_ready", 64'(exe_ready), 64'd1);
    checkOutput("t28_lsu_ready", 64'(lsu_ready), 64'd1);
    cycle(1);
    applyStimulus(0, '0, '0, 0, '0, '0);
    checkOutput("t28_busy", 64'(busy_mask), 64'h18);
    checkOutput("t28_lsu_ready_gnt", 64'(lsu_ready), 64'd1);
    cycle(1);
    checkOutput("t28_first_addr", 64'(gpr_addr_rd), 64'd4);
    cycle(1);
    checkOutput("t28_second_we",   64'(gpr_we), 64'd1);
    checkOutput("t28_second_addr", 64'(gpr_addr_rd), 64'd3);
    drain("t28_drain");

    // rd 0: slot consumed, no write, address and data registers unchanged.
    applyStimulus(1, 5'd0, 32'h55, 0, '0, '0);
    checkOutput("t30_ready0", 64'(exe_ready), 64'd1);
    cycle(1);
    applyStimulus(0, '0, '0, 0, '0, '0);
    checkOutput("t30_busy0",  64'(busy_mask), 64'd0);
    checkOutput("t30_ready1", 64'(exe_ready), 64'd1);
    cycle(1);
    checkOutput("t30_we",   64'(gpr_we), 64'd0);
    checkOutput("t30_addr", 64'(gpr_addr_rd), 64'd3);
    checkOutput("t30_data", 64'(gpr_data_rd), 64'h11);
    checkOutput("t30_busy", 64'(busy_mask), 64'd0);
    cycle(1);

    // Same destination from both sources: both writes land, LSU first.
    applyStimulus(1, 5'd6, 32'hB, 1, 5'd6, 32'hA);
    expectWrite(5'd6, 32'hA);
    expectWrite(5'd6, 32'hB);
    cycle(1);
    applyStimulus(0, '0, '0, 0, '0, '0);
    checkOutput("same_rd_busy", 64'(busy_mask), 64'h40);
    drain("same_rd_drain");

    // LSU streaming with one EXE request: EXE loses three times, then wins.
    foreach (exp_q[i]) ;
    expectWrite(5'd10, 32'h10A);
    expectWrite(5'd11, 32'h10B);
    expectWrite(5'd12, 32'h10C);
    expectWrite(5'd13, 32'h10D);
    expectWrite(5'd7,  32'h77);
    expectWrite(5'd14, 32'h10E);
    expectWrite(5'd15, 32'h10F);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      lsu_valid = 1'b1;
      lsu_rd    = 5'(10 + i);
      lsu_data  = 32'(32'h100 + 10 + i);
      if (i == 1) begin
        exe_valid = 1'b1;
        exe_rd    = 5'd7;
        exe_data  = 32'h77;
        checkOutput("t29_exe_ready", 64'(exe_ready), 64'd1);
      end
      guard = 0;
      while (!lsu_ready && guard < 20) begin
        cycle(1);
        exe_valid = 1'b0;
        stalls++;
        guard++;
      end
      if (guard >= 20) checkOutput("t29_lsu_timeout", 64'(guard), 64'd0);
      cycle(1);
      exe_valid = 1'b0;
    end
    applyStimulus(0, '0, '0, 0, '0, '0);
    checkOutput("t29_stalls", 64'(stalls), 64'd1);
    drain("t29_drain");

    // Reset with both buffers full: everything pending is dropped.
    applyStimulus(1, 5'd8, 32'h88, 1, 5'd9, 32'h99);
    cycle(1);
    rst_n = 1'b0;
    applyStimulus(1, 5'd12, 32'hCC, 1, 5'd13, 32'hDD);
    #1;
    checkOutput("t31_exe_ready_rst", 64'(exe_ready), 64'd0);
    checkOutput("t31_lsu_ready_rst", 64'(lsu_ready), 64'd0);
    cycle(1);
    rst_n = 1'b1;
    applyStimulus(0, '0, '0, 0, '0, '0);
    #1;
    checkOutput("t31_busy",      64'(busy_mask), 64'd0);
    checkOutput("t31_we",        64'(gpr_we), 64'd0);
    checkOutput("t31_addr",      64'(gpr_addr_rd), 64'd0);
    checkOutput("t31_data",      64'(gpr_data_rd), 64'd0);
    checkOutput("t31_exe_ready", 64'(exe_ready), 64'd1);
    checkOutput("t31_lsu_ready", 64'(lsu_ready), 64'd1);
    cycle(4);
    checkOutput("t31_idle_we",   64'(gpr_we), 64'd0);
    checkOutput("t31_idle_busy", 64'(busy_mask), 64'd0);

`ifdef GPR_WB_DBG_PORT_EN
    // Debug request waits until the EXE stream stops.
    expectWrite(5'd1, 32'hE1);
    expectWrite(5'd2, 32'hE2);
    expectWrite(5'd3, 32'hE3);
    expectWrite(5'd9, 32'hD9);
    applyStimulus(1, 5'd1, 32'hE1, 0, '0, '0);
    dbg_valid = 1'b1;
    dbg_rd    = 5'd9;
    dbg_data  = 32'hD9;
    checkOutput("dbg_ready", 64'(dbg_ready), 64'd1);
    cycle(1);
    dbg_valid = 1'b0;
    checkOutput("dbg_busy", 64'(busy_mask[9]), 64'd1);
    applyStimulus(1, 5'd2, 32'hE2, 0, '0, '0);
    cycle(1);
    applyStimulus(1, 5'd3, 32'hE3, 0, '0, '0);
    cycle(1);
    applyStimulus(0, '0, '0, 0, '0, '0);
    drain("dbg_drain");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
